// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready stream pair between producer, FIFO controller and consumer.
// The controller takes the slave view; the surrounding datapath takes the master view.
interface ram_fifo_ctrl_if #(
    parameter int DW = 64
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external synchronous RAM with 1-cycle read latency.
// Prefetched reads land in a 2-entry skid buffer that drives the output stream.
module ram_fifo_ctrl #(
    parameter int DW    = 64,
    parameter int AW    = 64,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_fifo_ctrl_if.slave    bus,
    output logic [3:0]        level,
    output logic              ram_wr_en,
    output logic [DW-1:0]     ram_data_in,
    output logic [AW-1:0]     ram_addr_wr,
    output logic [AW-1:0]     ram_addr_rd,
    input  logic [DW-1:0]     ram_data_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] stored;
    logic          pend;
    logic          ready_en;
    logic [1:0]    occ;
    logic [DW-1:0] skid_head;
    logic [DW-1:0] skid_tail;

    logic          in_ready_int;
    logic          accept;
    logic          pop;
    logic          issue;
    logic [2:0]    rd_backlog;

    // ready_en keeps in_ready low through reset and for the first edge after release
    always_comb begin
        in_ready_int = ready_en && (stored < CW'(DEPTH));
        accept       = bus.in_valid && in_ready_int;
        pop          = (occ != 2'd0) && bus.out_ready;
        rd_backlog   = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
        issue        = (stored != '0) && (rd_backlog <= 3'd1);
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = skid_head;

    assign ram_wr_en   = accept;
    assign ram_data_in = bus.in_data;
    assign ram_addr_wr = AW'(wr_ptr);
    assign ram_addr_rd = AW'(rd_ptr);

    assign level = 4'(stored) + 4'(pend) + 4'(occ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            stored   <= '0;
            pend     <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            stored <= stored + CW'(accept) - CW'(issue);
            pend   <= issue;
        end
    end

    // Skid buffer: push is the RAM word returning from last cycle's issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            skid_head <= '0;
            skid_tail <= '0;
        end else begin
            case ({pend, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid_head <= ram_data_out;
                    end else begin
                        skid_tail <= ram_data_out;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid_head <= skid_tail;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        skid_head <= skid_tail;
                        skid_tail <= ram_data_out;
                    end else begin
                        skid_head <= ram_data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller that wraps the team's 4-entry x 64-bit synchronous RAM (registered read, 1-cycle read latency, 64-bit address ports).
- Accepts a valid/ready input stream and drives the RAM write port.
- Issues prefetch reads and absorbs the RAM read latency in a 2-entry output skid buffer, presenting a valid/ready output stream.
- Sits between the producer datapath and the RAM; the RAM instance is external and connected via the ram_* ports.

Parameters:
- DW, 64, data width; must equal the RAM data width.
- AW, 64, RAM address port width; only the low log2(DEPTH) bits are non-zero.
- DEPTH, 4, RAM entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller can accept.
- in_data  in  DW  write data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DW  head-of-FIFO data.
- level  out  4  total words held: RAM + pending read + skid buffer (0..DEPTH+2).
- ram_wr_en  out  1  to RAM wr_en.
- ram_data_in  out  DW  to RAM data_in.
- ram_addr_wr  out  AW  to RAM addr_wr.
- ram_addr_rd  out  AW  to RAM addr_rd.
- ram_data_out  in  DW  from RAM data_out; valid the cycle after the address is sampled.

Behaviour:
- **Reset.** Asynchronous assert, synchronous-safe release. Clears wr_ptr, rd_ptr, stored, pend, skid occupancy and level to 0. Forces in_ready=0, out_valid=0, out_data=0, ram_wr_en=0, and all ram_addr_* to 0. RAM contents are not cleared and are never read before being rewritten.
- **Reset mid-operation.** All in-flight words are discarded. The first post-reset read returns only data written after reset.
- **Write side.**
  - in_ready = (stored < DEPTH), computed from registered state only. It never depends on a same-cycle read issue.
  - Accept = in_valid && in_ready. On accept, ram_wr_en=1 (combinational), ram_addr_wr = zero-extended wr_ptr, ram_data_in = in_data. wr_ptr increments mod DEPTH at the edge.
  - When not accepting, ram_wr_en=0. ram_data_in/ram_addr_wr are don't-care but driven (no X).
- **Read issue.**
  - pop = out_valid && out_ready.
  - issue = (stored > 0) && (occ + pend - pop <= 1).
  - On issue, ram_addr_rd = zero-extended rd_ptr. rd_ptr increments mod DEPTH and pend is set for the next cycle. Otherwise ram_addr_rd holds rd_ptr.
- **stored counter.** stored counts words written but not yet issued: +1 on accept, -1 on issue, unchanged when both occur in the same cycle.
- **No read/write collision.** A read is never issued to the slot being written in the same cycle. When stored==0 there is no issue; when stored==DEPTH there is no accept; otherwise wr_ptr != rd_ptr.
- **Capture.** In the cycle where pend=1, ram_data_out is pushed into the skid buffer at the edge. pend clears unless a new issue occurs in that same cycle.
- **Skid buffer.**
  - 2 entries, FIFO order; out_data = head entry, registered.
  - Simultaneous push and pop keeps occ unchanged and preserves order.
  - Overflow is impossible by the issue rule; the bench asserts occ <= 2 at all times.
- **out_valid and data stability.** out_valid = (occ > 0). out_data is stable while out_valid && !out_ready.
- **Latency.** A word accepted at edge E appears with out_valid=1 after edge E+2 when the FIFO is empty.
- **Throughput.** With in_valid and out_ready held high, one word per cycle in steady state.
- **Capacity.** DEPTH+2 = 6 words. in_ready drops when stored reaches DEPTH with the skid buffer full.
- **level.** level = stored + pend + occ. It updates every edge and is never above DEPTH+2.
- **Pointer wrap.** Pointers wrap silently at DEPTH-1 -> 0. Ordering is preserved across the wrap.

Test Plan:
1. **Reset.** rst_n low mid-stream with level=5 -> all outputs 0 immediately; after release, in_ready=1 one cycle later, level=0, out_valid=0.
2. **Single word.** One word 0xDEADBEEF_00000001 accepted at edge E -> ram_wr_en=1 with ram_addr_wr=0 at E; read issued with ram_addr_rd=0 the next cycle; out_valid=1 with out_data=0xDEADBEEF_00000001 after E+2.
3. **Fill with out_ready=0.** Push 0x1..0x8 -> exactly 6 accepted (0x1..0x6); in_ready=0 with level=6; then drain -> 0x1..0x6 in order, level returns to 0.
4. **Streaming across wrap.** in_valid and out_ready high for 20 words 0x100..0x113 -> output order matches, one word per cycle after the 2-cycle fill; ram_addr_wr/ram_addr_rd cycle 0,1,2,3,0; upper AW-2 bits always 0.
5. **Backpressure toggle.** out_ready toggled 1010... under random in_valid -> no loss or duplication; out_data stable while stalled; occ <= 2 and level <= 6 throughout (scoreboard).
6. **Simultaneous events.** Accept and pop in the same cycle at level=3 -> level stays 3; stored unchanged when accept and issue coincide.
